// File: rtl/tinyml_pkg.sv
// rtl/tinyml_pkg.sv - shared constants, load/store FSM states and tile byte range helper
package tinyml_pkg;

  localparam int TILE_W     = 256;
  localparam int DATA_W     = 8;
  localparam int ELEM_COUNT = TILE_W / DATA_W;
  localparam int LEN_W      = 10;
  localparam int ADDR_W     = 24;
  localparam int BITS_W     = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TILE,
    ST_WRITING,
    ST_DONE
  } ls_state_e;

  // Byte byte_idx of the current tile lies inside the transfer when its first bit is below len.
  function automatic logic byte_in_range(input logic [BITS_W-1:0] bits_done,
                                         input logic [BITS_W-1:0] byte_idx,
                                         input logic [LEN_W-1:0]  len);
    logic [BITS_W-1:0] first_bit;
    first_bit = bits_done + (byte_idx << 3);
    return first_bit < {1'b0, len};
  endfunction

endpackage

// File: rtl/store_v.sv
// rtl/store_v.sv - vector tile store engine: serialises tiles into byte writes on a memory port
module store_v
  import tinyml_pkg::*;
#(
  parameter int TILE_WIDTH = TILE_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [ADDR_WIDTH-1:0] dram_addr,
  input  logic [LEN_W-1:0]      length,
  input  logic [DATA_WIDTH-1:0] data_in [0:TILE_WIDTH/DATA_WIDTH-1],
  input  logic                  tile_in,
  output logic                  tile_ready,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_din,
  output logic                  valid_out
);

  localparam int E    = TILE_WIDTH / DATA_WIDTH;
  localparam int BC_W = (E > 1) ? $clog2(E) : 1;
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(E - 1);

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $fatal(1, "store_v: DATA_WIDTH must be 8");
  end
  if (TILE_WIDTH % 8 != 0) begin : g_bad_tile_width
    $fatal(1, "store_v: TILE_WIDTH must be a multiple of 8");
  end

  ls_state_e             state, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_cnt, addr_d;
  logic [BITS_W-1:0]     bits_done, bits_d, bits_next;
  logic [BC_W-1:0]       byte_cnt, byte_d;
  logic                  last_pend, last_d;
  logic                  load_tile;
  logic [DATA_WIDTH-1:0] tile_buf [0:E-1];

  logic                  tile_ready_d, busy_d, mem_we_d, valid_out_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [7:0]            mem_din_d;

  // Byte 0 is written on the acceptance edge, so last_pend always describes the byte
  // just written and the end-of-tile decision costs no extra idle cycle.
  always_comb begin
    state_d      = state;
    len_d        = len_q;
    addr_d       = addr_cnt;
    bits_d       = bits_done;
    bits_next    = bits_done + BITS_W'(TILE_WIDTH);
    byte_d       = byte_cnt;
    last_d       = last_pend;
    load_tile    = 1'b0;
    tile_ready_d = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_din_d    = mem_din;
    valid_out_d  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (valid_in) begin
          len_d  = length;
          addr_d = dram_addr;
          bits_d = '0;
          byte_d = '0;
          last_d = 1'b0;
          if (length == '0) begin
            state_d     = ST_DONE;
            valid_out_d = 1'b1;
          end else begin
            state_d      = ST_WAIT_TILE;
            tile_ready_d = 1'b1;
          end
        end
      end

      ST_WAIT_TILE: begin
        tile_ready_d = 1'b1;
        if (tile_ready && tile_in) begin
          load_tile    = 1'b1;
          state_d      = ST_WRITING;
          tile_ready_d = 1'b0;
          mem_we_d     = 1'b1;
          mem_addr_d   = addr_cnt;
          mem_din_d    = data_in[0];
          addr_d       = addr_cnt + 1'b1;
          byte_d       = BC_W'(1);
          last_d       = (E == 1) || !byte_in_range(bits_done, BITS_W'(1), len_q);
        end
      end

      ST_WRITING: begin
        if (last_pend) begin
          bits_d = bits_next;
          if (bits_next < {1'b0, len_q}) begin
            state_d      = ST_WAIT_TILE;
            tile_ready_d = 1'b1;
          end else begin
            state_d     = ST_DONE;
            valid_out_d = 1'b1;
          end
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = addr_cnt;
          mem_din_d  = tile_buf[byte_cnt];
          addr_d     = addr_cnt + 1'b1;
          byte_d     = byte_cnt + 1'b1;
          last_d     = (byte_cnt == LAST_IDX) ||
                       !byte_in_range(bits_done, BITS_W'(byte_cnt) + BITS_W'(1), len_q);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_WAIT_TILE) || (state_d == ST_WRITING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      addr_cnt   <= '0;
      bits_done  <= '0;
      byte_cnt   <= '0;
      last_pend  <= 1'b0;
      tile_ready <= 1'b0;
      busy       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      valid_out  <= 1'b0;
    end else begin
      len_q      <= len_d;
      addr_cnt   <= addr_d;
      bits_done  <= bits_d;
      byte_cnt   <= byte_d;
      last_pend  <= last_d;
      tile_ready <= tile_ready_d;
      busy       <= busy_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_din    <= mem_din_d;
      valid_out  <= valid_out_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < E; i++) tile_buf[i] <= '0;
    end else if (load_tile) begin
      for (int i = 0; i < E; i++) tile_buf[i] <= data_in[i];
    end
  end

endmodule

// File: tb/tb_store_v.sv
// tb/tb_store_v.sv - randomized scoreboard bench for store_v against a flat byte-stream model
module tb_store_v;
  import tinyml_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid_in = 1'b0;
  logic [ADDR_W-1:0] dram_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic [7:0]        data_in [0:ELEM_COUNT-1];
  logic              tile_in = 1'b0;
  logic              tile_ready, busy, mem_we, valid_out;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;

  store_v dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .dram_addr(dram_addr), .length(length),
    .data_in(data_in), .tile_in(tile_in), .tile_ready(tile_ready), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } exp_wr_t;

  exp_wr_t exp_w [$];
  int      exp_d [$];
  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  int      start_cyc = 0;
  int      last_we_cyc = 0;
  int      wr_cnt = 0;
  int      done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write and every completion is matched against the scoreboard queues.
  always @(negedge clk) begin
    exp_wr_t e;
    int      nb;
    if (rst) begin
      wr_cnt = 0;
    end else begin
      if (mem_we) begin
        if (exp_w.size() == 0) begin
          chk("unexpected_write", {8'h0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_w.pop_front();
          chk("write_addr", {8'h0, mem_addr}, {8'h0, e.a});
          chk("write_data", {24'h0, mem_din}, {24'h0, e.d});
          chk("ready_low_while_writing", {31'h0, tile_ready}, 32'h0);
        end
        last_we_cyc = cyc;
        wr_cnt++;
      end
      if (valid_out) begin
        if (exp_d.size() == 0) begin
          chk("unexpected_valid_out", 32'h1, 32'h0);
        end else begin
          nb = exp_d.pop_front();
          chk("write_count", wr_cnt, nb);
          chk("valid_out_cycle", cyc, (nb > 0) ? last_we_cyc + 1 : start_cyc + 1);
          chk("busy_low_at_done", {31'h0, busy}, 32'h0);
        end
        done_cnt++;
        wr_cnt = 0;
      end
    end
  end

  task automatic present_tile(input logic [7:0] tdat [0:127], input int t, input int dly);
    bit got;
    for (int d = 0; d < dly; d++) begin
      @(posedge clk); #1;
      valid_in  = (d == 0);
      dram_addr = ADDR_W'($urandom);
      length    = LEN_W'($urandom);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    for (int e = 0; e < ELEM_COUNT; e++) data_in[e] = tdat[t * ELEM_COUNT + e];
    tile_in = 1'b1;
    got = 1'b0;
    for (int g = 0; g < 200 && !got; g++) begin
      @(negedge clk);
      if (tile_ready) begin
        chk("busy_while_ready", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        got = 1'b1;
      end
    end
    chk("tile_accepted", {31'h0, got}, 32'h1);
    tile_in = 1'b0;
  endtask

  // Expected writes are the first ceil(length/8) bytes of the concatenated tiles,
  // landing at consecutive addresses modulo 2^ADDR_W.
  task automatic start_xfer(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                            input logic [7:0] tdat [0:127]);
    int nbytes;
    nbytes = (int'(len) + 7) / 8;
    for (int i = 0; i < nbytes; i++) exp_w.push_back('{a: ADDR_W'(a + ADDR_W'(i)), d: tdat[i]});
    exp_d.push_back(nbytes);
    @(posedge clk); #1;
    valid_in  = 1'b1;
    dram_addr = a;
    length    = len;
    start_cyc = cyc;
    @(posedge clk); #1;
    valid_in  = 1'b0;
    dram_addr = ADDR_W'($urandom);
    length    = LEN_W'($urandom);
  endtask

  task automatic do_xfer(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                         input int dly, input bit seq_data);
    logic [7:0] tdat [0:127];
    int         ntiles;
    int         d0;
    bit         saw_ready;
    for (int i = 0; i < 128; i++) tdat[i] = seq_data ? 8'(i) : 8'($urandom);
    ntiles = (int'(len) + TILE_W - 1) / TILE_W;
    d0 = done_cnt;
    start_xfer(a, len, tdat);
    for (int t = 0; t < ntiles; t++) present_tile(tdat, t, dly);
    saw_ready = 1'b0;
    for (int g = 0; g < 300 && done_cnt == d0; g++) begin
      @(negedge clk); #1;
      saw_ready |= tile_ready;
    end
    chk("transfer_done", done_cnt, d0 + 1);
    if (len == '0) chk("zero_len_no_ready", {31'h0, saw_ready}, 32'h0);
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_mid_tile();
    logic [7:0] tdat [0:127];
    int         d0;
    for (int i = 0; i < 128; i++) tdat[i] = 8'($urandom);
    d0 = done_cnt;
    start_xfer(24'h003000, 10'd256, tdat);
    for (int e = 0; e < ELEM_COUNT; e++) data_in[e] = tdat[e];
    tile_in = 1'b1;
    for (int g = 0; g < 200 && wr_cnt < 10; g++) begin
      @(negedge clk); #1;
    end
    chk("reached_byte_10", wr_cnt, 10);
    tile_in = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort_mem_we", {31'h0, mem_we}, 32'h0);
    chk("abort_valid_out", {31'h0, valid_out}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    exp_w.delete();
    exp_d.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    chk("abort_no_done", done_cnt, d0);
  endtask

  initial begin
    for (int e = 0; e < ELEM_COUNT; e++) data_in[e] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tile_ready", {31'h0, tile_ready}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_mem_we", {31'h0, mem_we}, 32'h0);
    chk("reset_mem_addr", {8'h0, mem_addr}, 32'h0);
    chk("reset_mem_din", {24'h0, mem_din}, 32'h0);
    chk("reset_valid_out", {31'h0, valid_out}, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    do_xfer(24'h000100, 10'd256, 0, 1'b1);
    do_xfer(ADDR_W'($urandom), 10'd100, 0, 1'b0);
    do_xfer(ADDR_W'($urandom), 10'd512, 5, 1'b0);
    do_xfer(ADDR_W'($urandom), 10'd0, 0, 1'b0);
    do_xfer(24'hFFFFF0, 10'd256, 0, 1'b0);
    reset_mid_tile();
    do_xfer(ADDR_W'($urandom), 10'd1023, 0, 1'b0);
    do_xfer(ADDR_W'($urandom), 10'd1, 1, 1'b0);
    do_xfer(ADDR_W'($urandom), 10'd257, 2, 1'b0);
    for (int r = 0; r < 8; r++) begin
      do_xfer(ADDR_W'($urandom), LEN_W'($urandom_range(0, 1023)), $urandom_range(0, 3), 1'b0);
    end

    repeat (4) @(posedge clk);
    chk("writes_drained", exp_w.size(), 0);
    chk("dones_drained", exp_d.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
